lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store control unit between the execute stage and the data memory port of the RV151 core. Accepts one load or store per handshake, checks alignment, generates the word-aligned memory request with byte write mask, and, for loads, extracts and sign/zero-extends the returned word into `io_data_out`. `io_data_out` feeds the writeback select mux (`wb_sel` = 2). Only one request is outstanding at a time, and `io_busy` stalls the pipeline.

## Interface
Parameters: none. All widths are fixed at 32-bit data/address and a 4-bit byte mask.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `io_req_valid` in 1: execute stage presents a memory op.
- `io_req_ready` out 1: unit can accept; high only in IDLE.
- `io_req_we` in 1: 1 = store, 0 = load.
- `io_req_funct3` in 3: RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `io_req_addr` in 32: byte address.
- `io_req_wdata` in 32: store data, right-justified.
- `io_mem_req_valid` out 1: memory request valid.
- `io_mem_req_ready` in 1: memory accepts request.
- `io_mem_we` out 1: write enable.
- `io_mem_addr` out 32: word address, equal to `{addr[31:2], 2'b00}`.
- `io_mem_wdata` out 32: store data shifted to its lanes.
- `io_mem_wmask` out 4: byte-lane enables; 0 for loads.
- `io_mem_resp_valid` in 1: load data valid.
- `io_mem_resp_data` in 32: raw load word.
- `io_data_out` out 32: extended load result, registered.
- `io_data_valid` out 1: one-cycle pulse when `io_data_out` updates.
- `io_misaligned` out 1: one-cycle pulse when a request is rejected.
- `io_busy` out 1: equal to `state != IDLE`.

## Operation
States: IDLE, ISSUE, WAIT, ERR.

- **IDLE**: a request is accepted when `io_req_valid && io_req_ready`. The unit latches `we`, `funct3`, `addr` and `wdata`.
  - The request is rejected, going to ERR, if any of these hold: halfword with `addr[0]`=1; word with `addr[1:0]`≠0; `funct3` is not a legal code for the op (3, 6, 7 for loads; ≥3 for stores).
  - Otherwise the unit goes to ISSUE.
- **ISSUE**: `io_mem_req_valid`=1. Address, wdata, wmask and we are driven from the latched values and stay stable until `io_mem_req_ready`.
  - On handshake, a store goes to IDLE, because stores complete at the handshake and no response is expected.
  - On handshake, a load goes to WAIT.
- **WAIT**: the unit waits for `io_mem_resp_valid`. On resp, it selects the byte or half by `addr[1:0]`, extends it per `funct3`, registers the result into `io_data_out`, pulses `io_data_valid` the next cycle, and goes to IDLE.
- **ERR**: `io_misaligned`=1 for exactly one cycle, then the unit goes to IDLE. No memory access is made.
- **Store lanes**:
  - SB: mask `4'b0001 << addr[1:0]`, wdata byte replicated ×4.
  - SH: mask `4'b0011 << addr[1:0]`, wdata half replicated ×2.
  - SW: mask `4'hF`.
- `io_mem_resp_valid` outside WAIT is ignored.
- `io_data_out` holds its last value between loads. Stores and rejects never modify it.

## Timing
- Reset (async assert): state=IDLE. All outputs are 0 except `io_req_ready`=1. `io_data_out`=0.
- Reset is released synchronously to `clock` by the integrator. Reset mid-operation abandons any in-flight request: the unit drops `io_mem_req_valid` immediately, and a later response is ignored.
- The accept cycle is T. `io_mem_req_valid` rises at T+1.
- With zero-wait memory (ready at T+1, resp at T+2):
  - `io_data_valid` and the new `io_data_out` appear at T+3.
  - `io_req_ready` is high again at T+3.
- A store with ready at T+1 gives `io_req_ready` at T+2.
- A reject gives `io_misaligned` at T+1 and `io_req_ready` at T+2.
- The response is never consumed in the same cycle as the request handshake. The earliest accepted response is one cycle after the handshake.
- `io_data_valid` and `io_req_ready` are high in the same cycle, so a new request can be accepted in the cycle `io_data_valid` pulses.

## Structure
- **Package `lsu_pkg`**: funct3 constants (`LB`=0, `LH`=1, `LW`=2, `LBU`=4, `LHU`=5, `SB`=0, `SH`=1, `SW`=2) and the state enum.
- **Sub-module `lsu_align`** (combinational):
  - store lane shift and mask generation;
  - load byte/half select and sign/zero extension.
- **`lsu_ctrl`** holds the FSM and the registers.

## Test plan
- **LB sign extension.** Set `mem[0x100]` to `0x80FF7F01`. Load LB at 0x103.
  - Expect `io_mem_addr`=0x100 and `io_data_out`=0xFFFFFF80.
  - LBU at 0x103 gives 0x00000080.
- **SH to upper half.** SH with `addr`=0x202 and `wdata`=0x1234ABCD.
  - Expect `io_mem_wmask`=4'b1100 and `io_mem_wdata`=0xABCDABCD.
  - `io_req_ready` is back at T+2.
- **Misaligned reject.** LW with `addr`=0x301.
  - Expect `io_misaligned` pulse at T+1.
  - `io_mem_req_valid` is never asserted and `io_data_out` is unchanged.
- **Backpressure.** Hold `io_mem_req_ready`=0 for 5 cycles during a LH at 0x402.
  - `io_mem_addr`, `io_mem_wmask` and `io_mem_we` must be stable throughout.
  - After resp 0x8001xxxx, `io_data_out`=0xFFFF8001.
- **Spurious response.** Assert `io_mem_resp_valid` while the unit is in IDLE.
  - `io_data_valid` stays 0 and `io_data_out` does not change.
- **Reset during WAIT.** Assert `reset`=0 while the unit is in WAIT.
  - All outputs go to reset values asynchronously.
  - A response arriving after release is ignored.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_pkg : funct3 codes, FSM states and request legality check   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package lsu_pkg;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    // Width code is funct3[1:0]: 1 = halfword, 2 = word, for loads and stores alike.
    function automatic logic req_illegal(input logic       we,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addr_lo);
        logic bad_code;
        logic bad_align;
        bad_code  = we ? (funct3 > SW) : ((funct3 == 3'd3) || (funct3 > LHU));
        bad_align = ((funct3[1:0] == 2'd1) && addr_lo[0]) ||
                    ((funct3[1:0] == 2'd2) && (addr_lo != 2'd0));
        return bad_code || bad_align;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_align : store lane/mask generation, load select and extend  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module lsu_align
    import lsu_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_store_wdata,
    output logic [3:0]  o_store_wmask,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_store_wmask = 4'b0000;
        o_store_wdata = i_wdata;
        case (i_funct3[1:0])
            2'd0: begin
                o_store_wmask = 4'b0001 << i_addr_lo;
                o_store_wdata = {4{i_wdata[7:0]}};
            end
            2'd1: begin
                o_store_wmask = 4'b0011 << i_addr_lo;
                o_store_wdata = {2{i_wdata[15:0]}};
            end
            default: o_store_wmask = 4'b1111;
        endcase
        // Loads never write memory lanes.
        if (!i_we) begin
            o_store_wmask = 4'b0000;
        end
    end

    always_comb begin
        o_load_data = i_rdata;
        case (i_funct3)
            LB:      o_load_data = {{24{w_byte[7]}}, w_byte};
            LH:      o_load_data = {{16{w_half[15]}}, w_half};
            LBU:     o_load_data = {24'd0, w_byte};
            LHU:     o_load_data = {16'd0, w_half};
            default: o_load_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | lsu_ctrl : single-outstanding load/store unit, FSM + registers  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module lsu_ctrl
    import lsu_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_valid,
    output logic        io_req_ready,
    input  logic        io_req_we,
    input  logic [2:0]  io_req_funct3,
    input  logic [31:0] io_req_addr,
    input  logic [31:0] io_req_wdata,
    output logic        io_mem_req_valid,
    input  logic        io_mem_req_ready,
    output logic        io_mem_we,
    output logic [31:0] io_mem_addr,
    output logic [31:0] io_mem_wdata,
    output logic [3:0]  io_mem_wmask,
    input  logic        io_mem_resp_valid,
    input  logic [31:0] io_mem_resp_data,
    output logic [31:0] io_data_out,
    output logic        io_data_valid,
    output logic        io_misaligned,
    output logic        io_busy
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] data_out_q, data_out_d;
    logic        data_valid_q, data_valid_d;

    logic        w_issue;
    logic [31:0] w_store_wdata;
    logic [3:0]  w_store_wmask;
    logic [31:0] w_load_data;

    lsu_align u_align (
        .i_we          (we_q),
        .i_funct3      (funct3_q),
        .i_addr_lo     (addr_q[1:0]),
        .i_wdata       (wdata_q),
        .i_rdata       (io_mem_resp_data),
        .o_store_wdata (w_store_wdata),
        .o_store_wmask (w_store_wmask),
        .o_load_data   (w_load_data)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            data_out_q   <= 32'd0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (io_req_valid) begin
                    we_d     = io_req_we;
                    funct3_d = io_req_funct3;
                    addr_d   = io_req_addr;
                    wdata_d  = io_req_wdata;
                    state_d  = req_illegal(io_req_we, io_req_funct3, io_req_addr[1:0])
                               ? S_ERR : S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Stores retire at the handshake; only loads wait for data.
                if (io_mem_req_ready) begin
                    state_d = we_q ? S_IDLE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_mem_resp_valid) begin
                    data_out_d   = w_load_data;
                    data_valid_d = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Memory-side outputs are zero outside ISSUE so reset and idle look identical.
    assign w_issue          = (state_q == S_ISSUE);
    assign io_req_ready     = (state_q == S_IDLE);
    assign io_busy          = (state_q != S_IDLE);
    assign io_misaligned    = (state_q == S_ERR);
    assign io_mem_req_valid = w_issue;
    assign io_mem_we        = w_issue & we_q;
    assign io_mem_addr      = w_issue ? {addr_q[31:2], 2'b00} : 32'd0;
    assign io_mem_wdata     = w_issue ? w_store_wdata : 32'd0;
    assign io_mem_wmask     = w_issue ? w_store_wmask : 4'b0000;
    assign io_data_out      = data_out_q;
    assign io_data_valid    = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_lsu_ctrl : directed vector bench for lsu_ctrl                |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_lsu_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_req_valid = 1'b0;
    logic        io_req_ready;
    logic        io_req_we = 1'b0;
    logic [2:0]  io_req_funct3 = 3'd0;
    logic [31:0] io_req_addr = 32'd0;
    logic [31:0] io_req_wdata = 32'd0;
    logic        io_mem_req_valid;
    logic        io_mem_req_ready = 1'b0;
    logic        io_mem_we;
    logic [31:0] io_mem_addr;
    logic [31:0] io_mem_wdata;
    logic [3:0]  io_mem_wmask;
    logic        io_mem_resp_valid = 1'b0;
    logic [31:0] io_mem_resp_data = 32'd0;
    logic [31:0] io_data_out;
    logic        io_data_valid;
    logic        io_misaligned;
    logic        io_busy;

    always #5 clock = ~clock;

    lsu_ctrl dut (
        .clock             (clock),
        .reset             (reset),
        .io_req_valid      (io_req_valid),
        .io_req_ready      (io_req_ready),
        .io_req_we         (io_req_we),
        .io_req_funct3     (io_req_funct3),
        .io_req_addr       (io_req_addr),
        .io_req_wdata      (io_req_wdata),
        .io_mem_req_valid  (io_mem_req_valid),
        .io_mem_req_ready  (io_mem_req_ready),
        .io_mem_we         (io_mem_we),
        .io_mem_addr       (io_mem_addr),
        .io_mem_wdata      (io_mem_wdata),
        .io_mem_wmask      (io_mem_wmask),
        .io_mem_resp_valid (io_mem_resp_valid),
        .io_mem_resp_data  (io_mem_resp_data),
        .io_data_out       (io_data_out),
        .io_data_valid     (io_data_valid),
        .io_misaligned     (io_misaligned),
        .io_busy           (io_busy)
    );

    typedef struct packed {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] resp;
        logic        exp_rej;
        logic [31:0] exp_addr;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wdata;
        logic [31:0] exp_out;
    } vec_t;

    localparam int NVEC = 14;
    vec_t        vecs [NVEC];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_out = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept at T, zero-wait memory: ready at T+1, response at T+2.
    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clock);
        chk({tag, ".ready_T"}, {31'd0, io_req_ready}, 32'd1);
        io_req_valid  = 1'b1;
        io_req_we     = v.we;
        io_req_funct3 = v.f3;
        io_req_addr   = v.addr;
        io_req_wdata  = v.wdata;
        @(negedge clock);
        io_req_valid = 1'b0;
        if (v.exp_rej) begin
            chk({tag, ".misaligned_T1"}, {31'd0, io_misaligned}, 32'd1);
            chk({tag, ".memvalid_T1"}, {31'd0, io_mem_req_valid}, 32'd0);
            @(negedge clock);
            chk({tag, ".misaligned_T2"}, {31'd0, io_misaligned}, 32'd0);
            chk({tag, ".memvalid_T2"}, {31'd0, io_mem_req_valid}, 32'd0);
            chk({tag, ".ready_T2"}, {31'd0, io_req_ready}, 32'd1);
            chk({tag, ".data_out"}, io_data_out, model_out);
        end else begin
            chk({tag, ".memvalid_T1"}, {31'd0, io_mem_req_valid}, 32'd1);
            chk({tag, ".mem_addr"}, io_mem_addr, v.exp_addr);
            chk({tag, ".mem_we"}, {31'd0, io_mem_we}, {31'd0, v.we});
            chk({tag, ".mem_wmask"}, {28'd0, io_mem_wmask}, {28'd0, v.exp_mask});
            if (v.we) chk({tag, ".mem_wdata"}, io_mem_wdata, v.exp_wdata);
            io_mem_req_ready = 1'b1;
            // A response during the handshake cycle must be ignored.
            io_mem_resp_valid = 1'b1;
            io_mem_resp_data  = ~v.resp;
            @(negedge clock);
            io_mem_req_ready  = 1'b0;
            io_mem_resp_valid = 1'b0;
            if (v.we) begin
                chk({tag, ".ready_T2"}, {31'd0, io_req_ready}, 32'd1);
                chk({tag, ".data_out"}, io_data_out, model_out);
            end else begin
                chk({tag, ".busy_T2"}, {31'd0, io_busy}, 32'd1);
                chk({tag, ".dvalid_T2"}, {31'd0, io_data_valid}, 32'd0);
                io_mem_resp_valid = 1'b1;
                io_mem_resp_data  = v.resp;
                @(negedge clock);
                io_mem_resp_valid = 1'b0;
                model_out = v.exp_out;
                chk({tag, ".dvalid_T3"}, {31'd0, io_data_valid}, 32'd1);
                chk({tag, ".data_out"}, io_data_out, model_out);
                chk({tag, ".ready_T3"}, {31'd0, io_req_ready}, 32'd1);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".ready"}, {31'd0, io_req_ready}, 32'd1);
        chk({tag, ".busy"}, {31'd0, io_busy}, 32'd0);
        chk({tag, ".memvalid"}, {31'd0, io_mem_req_valid}, 32'd0);
        chk({tag, ".mem_addr"}, io_mem_addr, 32'd0);
        chk({tag, ".mem_we_mask"}, {27'd0, io_mem_we, io_mem_wmask}, 32'd0);
        chk({tag, ".mem_wdata"}, io_mem_wdata, 32'd0);
        chk({tag, ".data_out"}, io_data_out, 32'd0);
        chk({tag, ".flags"}, {30'd0, io_data_valid, io_misaligned}, 32'd0);
    endtask

    initial begin
        //          we  f3    addr          wdata         resp          rej exp_addr      mask     exp_wdata     exp_out
        vecs[0]  = '{1'b0, 3'd0, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80};
        vecs[1]  = '{1'b0, 3'd4, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080};
        vecs[2]  = '{1'b0, 3'd1, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF};
        vecs[3]  = '{1'b0, 3'd5, 32'h0000_0100, 32'h0,        32'h80FF_7F01, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_7F01};
        vecs[4]  = '{1'b0, 3'd2, 32'h0000_0104, 32'h0,        32'hDEAD_BEEF, 1'b0, 32'h0000_0104, 4'b0000, 32'h0,        32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 3'd0, 32'h0000_0101, 32'h0,        32'h80FF_7F01, 1'b0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_007F};
        vecs[6]  = '{1'b1, 3'd1, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[7]  = '{1'b1, 3'd0, 32'h0000_0201, 32'h0000_00A5, 32'h0,        1'b0, 32'h0000_0200, 4'b0010, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, 3'd2, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,        1'b0, 32'h0000_0200, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b0, 3'd2, 32'h0000_0301, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 3'd1, 32'h0000_0303, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 3'd3, 32'h0000_0300, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[12] = '{1'b1, 3'd4, 32'h0000_0300, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};
        vecs[13] = '{1'b1, 3'd1, 32'h0000_0201, 32'h0,        32'h0,        1'b1, 32'h0,        4'b0000, 32'h0,        32'h0};

        // Reset state
        #12;
        chk_reset_outputs("reset");
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure on LH 0x402 for five cycles
        @(negedge clock);
        io_req_valid  = 1'b1;
        io_req_we     = 1'b0;
        io_req_funct3 = 3'd1;
        io_req_addr   = 32'h0000_0402;
        @(negedge clock);
        io_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("bp%0d.hold", c),
                {io_mem_req_valid, io_mem_we, io_mem_wmask, 26'd0}, {1'b1, 1'b0, 4'b0000, 26'd0});
            chk($sformatf("bp%0d.addr", c), io_mem_addr, 32'h0000_0400);
            @(negedge clock);
        end
        io_mem_req_ready = 1'b1;
        chk("bp.addr_final", io_mem_addr, 32'h0000_0400);
        @(negedge clock);
        io_mem_req_ready  = 1'b0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = 32'h8001_1234;
        @(negedge clock);
        io_mem_resp_valid = 1'b0;
        model_out = 32'hFFFF_8001;
        chk("bp.dvalid", {31'd0, io_data_valid}, 32'd1);
        chk("bp.data_out", io_data_out, model_out);

        // Spurious response while idle
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = 32'h5555_AAAA;
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            chk($sformatf("spur%0d.dvalid", c), {31'd0, io_data_valid}, 32'd0);
            chk($sformatf("spur%0d.data_out", c), io_data_out, model_out);
        end
        io_mem_resp_valid = 1'b0;

        // Reset while waiting on a load response
        @(negedge clock);
        io_req_valid  = 1'b1;
        io_req_funct3 = 3'd2;
        io_req_addr   = 32'h0000_0500;
        @(negedge clock);
        io_req_valid     = 1'b0;
        io_mem_req_ready = 1'b1;
        @(negedge clock);
        io_mem_req_ready = 1'b0;
        chk("rstw.in_wait", {31'd0, io_busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk_reset_outputs("rstw.async");
        @(negedge clock);
        reset = 1'b1;
        model_out = 32'd0;
        io_mem_resp_valid = 1'b1;
        io_mem_resp_data  = 32'h1357_9BDF;
        @(negedge clock);
        io_mem_resp_valid = 1'b0;
        chk("rstw.dvalid", {31'd0, io_data_valid}, 32'd0);
        chk("rstw.data_out", io_data_out, model_out);
        chk("rstw.ready", {31'd0, io_req_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
